// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer: load-use, mul/div occupancy, branch redirect, dmem freeze.
// Define HAZARD_PERF_CNT_EN to add the perf_* event counters.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 32,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  input  logic       md_done,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       md_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_lu_stall,
  output logic [CNT_W-1:0] perf_md_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_mem_stall
`endif
);

  localparam int MW = $clog2(MD_TIMEOUT + 1);
  localparam logic [MW-1:0] MD_MAX = MW'(MD_TIMEOUT);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t        state, state_n;
  logic [MW-1:0] md_cnt, md_cnt_n;
  logic          mem_freeze, load_use;
  logic          lu_hit, md_hit, br_hit, mem_hit;

  assign mem_freeze = dmem_req & ~dmem_ready;

  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
    ((id_use_rs1 & (ex_rd == id_rs1)) |
     (id_use_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_timeout  = 1'b0;
    state_n     = state;
    md_cnt_n    = md_cnt;
    lu_hit      = 1'b0;
    md_hit      = 1'b0;
    br_hit      = 1'b0;
    mem_hit     = 1'b0;
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      mem_hit    = 1'b1;
      // the mul/div unit keeps running while memory stalls
      if (state == MD_WAIT && md_cnt != MD_MAX)
        md_cnt_n = md_cnt + 1'b1;
    end else if (state == MD_WAIT) begin
      if (md_done) begin
        state_n  = RUN;
        md_cnt_n = '0;
      end else if (md_cnt == MD_MAX) begin
        md_timeout = 1'b1;
        state_n    = RUN;
        md_cnt_n   = '0;
      end else begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_flush = 1'b1;
        md_hit      = 1'b1;
        md_cnt_n    = md_cnt + 1'b1;
      end
    end else if (ex_md_start) begin
      if (!md_done) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_flush = 1'b1;
        md_hit      = 1'b1;
        state_n     = MD_WAIT;
        md_cnt_n    = MW'(1);
      end
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      br_hit     = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      lu_hit     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_stall  <= '0;
      perf_md_stall  <= '0;
      perf_flush     <= '0;
      perf_mem_stall <= '0;
    end else begin
      perf_lu_stall  <= perf_lu_stall + CNT_W'(lu_hit);
      perf_md_stall  <= perf_md_stall + CNT_W'(md_hit);
      perf_flush     <= perf_flush + CNT_W'(br_hit);
      perf_mem_stall <= perf_mem_stall + CNT_W'(mem_hit);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{lu_hit, md_hit, br_hit, mem_hit, CNT_W[0]};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table plus md/freeze/reset sequences.
// Expected output word is {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f, tmo}.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] E_DEF = 7'b1101000;
  localparam logic [6:0] E_LU  = 7'b0001100;
  localparam logic [6:0] E_BR  = 7'b1111100;
  localparam logic [6:0] E_FRZ = 7'b0000000;
  localparam logic [6:0] E_MD  = 7'b0000010;
  localparam logic [6:0] E_TMO = 7'b1101001;
  localparam logic [6:0] E_RST = 7'b0010100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
  logic       ex_branch_taken = 0, ex_md_start = 0, md_done = 0;
  logic       dmem_req = 0, dmem_ready = 0;
  logic       pc_write, ifid_write, ifid_flush, idex_write;
  logic       idex_flush, exmem_flush, md_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stall, perf_md_stall, perf_flush, perf_mem_stall;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_TIMEOUT(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .md_done(md_done),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .md_timeout(md_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lu_stall(perf_lu_stall), .perf_md_stall(perf_md_stall),
    .perf_flush(perf_flush), .perf_mem_stall(perf_mem_stall)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic [7:0] ctl;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(string n, logic [4:0] a, logic [4:0] b,
                              logic [4:0] d, logic [7:0] c, logic [6:0] e);
    vec_t v;
    v.name = n; v.rs1 = a; v.rs2 = b; v.rd = d; v.ctl = c; v.exp = e;
    return v;
  endfunction

  // ctl = {use1, use2, mem_read, branch, md_start, md_done, req, ready}
  task automatic apply(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [7:0] c);
    id_rs1 = a; id_rs2 = b; ex_rd = d;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken,
     ex_md_start, md_done, dmem_req, dmem_ready} = c;
  endtask

  task automatic cmp(input string n, input logic [6:0] exp);
    logic [6:0] got;
    got = {pc_write, ifid_write, ifid_flush, idex_write,
           idex_flush, exmem_flush, md_timeout};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", n, got, exp);
    end
  endtask

  task automatic cmp_val(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic step(input string n, input logic [6:0] exp);
    @(negedge clk);
    cmp(n, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 8'h00);
    rst_n = 1'b0;
    #12;
    cmp("reset_outputs", E_RST);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk("idle",        0, 0, 0, 8'b0000_0000, E_DEF);
    tbl[1]  = mk("lu_rs1",      5, 3, 5, 8'b1010_0000, E_LU);
    tbl[2]  = mk("lu_rs2",      1, 7, 7, 8'b0110_0000, E_LU);
    tbl[3]  = mk("after_lu",    0, 0, 0, 8'b0000_0000, E_DEF);
    tbl[4]  = mk("lu_no_use",   5, 5, 5, 8'b0010_0000, E_DEF);
    tbl[5]  = mk("lu_x0",       0, 0, 0, 8'b1110_0000, E_DEF);
    tbl[6]  = mk("no_memread",  5, 5, 5, 8'b1100_0000, E_DEF);
    tbl[7]  = mk("lu_and_br",   5, 0, 5, 8'b1011_0000, E_BR);
    tbl[8]  = mk("branch",      0, 0, 0, 8'b0001_0000, E_BR);
    tbl[9]  = mk("freeze",      0, 0, 0, 8'b0000_0010, E_FRZ);
    tbl[10] = mk("freeze_lu",   9, 0, 9, 8'b1010_0010, E_FRZ);
    tbl[11] = mk("md_done_now", 0, 0, 0, 8'b0000_1111, E_DEF);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].ctl);
      step(tbl[i].name, tbl[i].exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    cmp_val("perf_lu", int'(perf_lu_stall), 2);
    cmp_val("perf_flush", int'(perf_flush), 2);
    cmp_val("perf_mem", int'(perf_mem_stall), 2);
    cmp_val("perf_md0", int'(perf_md_stall), 0);
`endif

    // mul/div finishing four cycles after start
    do_reset();
    apply(0, 0, 0, 8'b0000_1000);
    step("md_start", E_MD);
    apply(0, 0, 0, 8'h00);
    for (int k = 1; k < 4; k++) step("md_wait", E_MD);
    md_done = 1'b1;
    step("md_done", E_DEF);
    md_done = 1'b0;
    step("md_after", E_DEF);
`ifdef HAZARD_PERF_CNT_EN
    cmp_val("perf_md4", int'(perf_md_stall), 4);
`endif

    // watchdog: no md_done at all
    apply(0, 0, 0, 8'b0000_1000);
    step("tmo_start", E_MD);
    apply(0, 0, 0, 8'h00);
    for (int k = 1; k < 32; k++) step("tmo_wait", E_MD);
    step("tmo_pulse", E_TMO);
    step("tmo_after", E_DEF);

    // freeze inside MD_WAIT with a branch pending; md_cnt keeps counting
    apply(0, 0, 0, 8'b0000_1000);
    step("frz_md_start", E_MD);
    apply(0, 0, 0, 8'h00);
    for (int k = 1; k < 5; k++) step("frz_md_wait", E_MD);
    apply(0, 0, 0, 8'b0001_0010);
    for (int k = 5; k < 8; k++) step("frz_md_frozen", E_FRZ);
    apply(0, 0, 0, 8'h00);
    for (int k = 8; k < 32; k++) step("frz_md_wait2", E_MD);
    step("frz_md_tmo", E_TMO);

    // branch held under freeze takes effect when freeze drops
    apply(0, 0, 0, 8'b0001_0010);
    step("br_frozen", E_FRZ);
    apply(0, 0, 0, 8'b0001_0000);
    step("br_released", E_BR);
    apply(0, 0, 0, 8'h00);

    // async reset in the middle of MD_WAIT
    apply(0, 0, 0, 8'b0000_1000);
    step("rst_md_start", E_MD);
    apply(0, 0, 0, 8'h00);
    step("rst_md_wait", E_MD);
    step("rst_md_wait", E_MD);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_md", E_RST);
`ifdef HAZARD_PERF_CNT_EN
    cmp_val("rst_perf_md", int'(perf_md_stall), 0);
`endif
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rst_md_run", E_DEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
